// File: rtl/qpsk_ber_checker_if.sv
// Sample stream from the QPSK tx shaping filter into the BER checker.
// Carries the shared sample strobe, the signed filter output and the
// reference bit that fed the filter.
interface qpsk_ber_checker_if;
    logic              i_enable;
    logic signed [7:0] i_sample;
    logic              i_ref;

    modport master (
        output i_enable,
        output i_sample,
        output i_ref
    );

    modport slave (
        input i_enable,
        input i_sample,
        input i_ref
    );
endinterface

// File: rtl/qpsk_ber_checker.sv
// QPSK receive-side BER checker.
// Picks one sampling phase out of OS, makes a hard sign decision per symbol,
// searches DEPTH candidate reference delays (WINDOW symbols each) for the one
// with the fewest mismatches, then locks and counts bits and bit errors.
// Optional build macro BER_EARLY_LOCK_EN: a window with zero mismatches locks
// immediately on that candidate instead of finishing the full search.
module qpsk_ber_checker #(
    parameter int OS     = 4,
    parameter int DEPTH  = 64,
    parameter int WINDOW = 511,
    parameter int CNT_W  = 64,
    localparam int PW    = $clog2(OS),
    localparam int DW    = $clog2(DEPTH),
    localparam int MW    = $clog2(WINDOW + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    qpsk_ber_checker_if.slave      stream,
    input  logic [PW-1:0]          i_phase,
    input  logic                   i_restart,
    output logic                   o_locked,
    output logic [DW-1:0]          o_delay,
    output logic [CNT_W-1:0]       o_bit_cnt,
    output logic [CNT_W-1:0]       o_err_cnt,
    output logic [MW-1:0]          o_min_err
);

    localparam logic [0:0] ST_SEARCH = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    localparam logic [MW-1:0] WIN_LAST  = MW'(WINDOW - 1);
    localparam logic [DW-1:0] CAND_LAST = DW'(DEPTH - 1);

    logic [PW-1:0]    phase_cnt;
    logic [DEPTH-1:0] ref_buf;
    logic [0:0]       state;
    logic [DW-1:0]    cand_d;
    logic [DW-1:0]    best_d;
    logic [MW-1:0]    win_cnt;
    logic [MW-1:0]    acc;

    logic             sym;
    logic             dec;
    logic             mis_search;
    logic             mis_lock;
    logic [MW-1:0]    total;
    logic             new_best;
    logic             early_hit;

    // The symbol strobe looks at the phase count before this cycle's increment.
    assign sym        = stream.i_enable && (phase_cnt == i_phase);
    assign dec        = ~stream.i_sample[7];
    assign mis_search = dec ^ ref_buf[cand_d];
    assign mis_lock   = dec ^ ref_buf[o_delay];
    assign total      = acc + MW'(mis_search);
    assign new_best   = (total < o_min_err);

`ifdef BER_EARLY_LOCK_EN
    assign early_hit = (total == '0);
`else
    assign early_hit = 1'b0;
`endif

    // Free-running sampling phase counter, advanced by the filter's sample strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_cnt <= '0;
        end else if (stream.i_enable) begin
            phase_cnt <= phase_cnt + PW'(1);
        end
    end

    // Reference delay line; keeps shifting through restarts so history is never lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ref_buf <= '0;
        end else if (sym) begin
            ref_buf <= {ref_buf[DEPTH-2:0], stream.i_ref};
        end
    end

    // Delay search, lock decision and locked-state bit/error counting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_SEARCH;
            cand_d    <= '0;
            best_d    <= '0;
            win_cnt   <= '0;
            acc       <= '0;
            o_locked  <= 1'b0;
            o_delay   <= '0;
            o_bit_cnt <= '0;
            o_err_cnt <= '0;
            o_min_err <= '1;
        end else if (i_restart) begin
            state     <= ST_SEARCH;
            cand_d    <= '0;
            best_d    <= '0;
            win_cnt   <= '0;
            acc       <= '0;
            o_locked  <= 1'b0;
            o_bit_cnt <= '0;
            o_err_cnt <= '0;
            o_min_err <= '1;
        end else if (sym) begin
            case (state)
                ST_SEARCH: begin
                    if (win_cnt == WIN_LAST) begin
                        acc     <= '0;
                        win_cnt <= '0;
                        if (early_hit) begin
                            state     <= ST_LOCKED;
                            o_locked  <= 1'b1;
                            o_delay   <= cand_d;
                            o_min_err <= '0;
                        end else begin
                            if (new_best) begin
                                o_min_err <= total;
                                best_d    <= cand_d;
                            end
                            if (cand_d == CAND_LAST) begin
                                state    <= ST_LOCKED;
                                o_locked <= 1'b1;
                                o_delay  <= new_best ? cand_d : best_d;
                            end else begin
                                cand_d <= cand_d + DW'(1);
                            end
                        end
                    end else begin
                        acc     <= total;
                        win_cnt <= win_cnt + MW'(1);
                    end
                end
                default: begin
                    if (o_bit_cnt != '1) begin
                        o_bit_cnt <= o_bit_cnt + CNT_W'(1);
                    end
                    if (mis_lock && (o_err_cnt != '1)) begin
                        o_err_cnt <= o_err_cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qpsk_ber_checker.sv
// Directed testbench for qpsk_ber_checker.
// Uses a reduced search (DEPTH=16, WINDOW=63) and CNT_W=10 so that lock,
// relock and counter saturation all fit in a short run. With
// BER_EARLY_LOCK_EN defined the expected lock point moves to the fifth window.
module tb_qpsk_ber_checker;

    localparam int OS     = 4;
    localparam int DEPTH  = 16;
    localparam int WINDOW = 63;
    localparam int CNT_W  = 10;

`ifdef BER_EARLY_LOCK_EN
    localparam int LOCK_SYMS = 5 * WINDOW;
`else
    localparam int LOCK_SYMS = DEPTH * WINDOW;
`endif

    localparam logic [63:0] MIN_ERR_RST = 64'd63;
    localparam logic [63:0] CNT_SAT     = 64'd1023;
    localparam logic [63:0] TRUE_DELAY  = 64'd4;

    logic             clk;
    logic             rst;
    logic [1:0]       i_phase;
    logic             i_restart;
    logic             o_locked;
    logic [3:0]       o_delay;
    logic [CNT_W-1:0] o_bit_cnt;
    logic [CNT_W-1:0] o_err_cnt;
    logic [5:0]       o_min_err;

    int errors;
    int checks;

    logic [8:0] prbs;
    logic [7:0] hist;

    qpsk_ber_checker_if stream_if ();

    qpsk_ber_checker #(
        .OS     (OS),
        .DEPTH  (DEPTH),
        .WINDOW (WINDOW),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .stream    (stream_if),
        .i_phase   (i_phase),
        .i_restart (i_restart),
        .o_locked  (o_locked),
        .o_delay   (o_delay),
        .o_bit_cnt (o_bit_cnt),
        .o_err_cnt (o_err_cnt),
        .o_min_err (o_min_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // One full symbol: OS enabled cycles. The sample at the selected phase
    // carries the reference bit from five symbols earlier (optionally
    // inverted); other phases carry the correct or the opposite sign.
    task automatic applyStimulus(input bit flip, input bit restart_at_sym, input bit wrong_off_phase);
        logic       ref_bit;
        logic [7:0] good;
        logic [7:0] bad;
        ref_bit = prbs[8] ^ prbs[4];
        prbs    = {prbs[7:0], ref_bit};
        good    = hist[4] ? 8'h40 : 8'hC0;
        bad     = hist[4] ? 8'hC0 : 8'h40;
        for (int p = 0; p < OS; p++) begin
            @(negedge clk);
            stream_if.i_enable = 1'b1;
            stream_if.i_ref    = ref_bit;
            if (p == int'(i_phase)) begin
                stream_if.i_sample = flip ? bad : good;
                i_restart          = restart_at_sym;
            end else begin
                stream_if.i_sample = wrong_off_phase ? bad : good;
                i_restart          = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        i_restart = 1'b0;
        hist = {hist[6:0], ref_bit};
    endtask

    task automatic runSymbols(input int n, input bit wrong_off_phase);
        for (int k = 0; k < n; k++) begin
            applyStimulus(1'b0, 1'b0, wrong_off_phase);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_locked"},  64'(o_locked),  64'd0);
        checkOutput({tag, "_delay"},   64'(o_delay),   64'd0);
        checkOutput({tag, "_bit_cnt"}, 64'(o_bit_cnt), 64'd0);
        checkOutput({tag, "_err_cnt"}, 64'(o_err_cnt), 64'd0);
        checkOutput({tag, "_min_err"}, 64'(o_min_err), MIN_ERR_RST);
    endtask

    task automatic releaseReset();
        @(negedge clk);
        stream_if.i_enable = 1'b0;
        hist = '0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        prbs   = 9'h1FF;
        hist   = '0;
        rst                = 1'b1;
        i_phase            = 2'd0;
        i_restart          = 1'b0;
        stream_if.i_enable = 1'b0;
        stream_if.i_sample = 8'h00;
        stream_if.i_ref    = 1'b0;

        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkResetState("por");
        releaseReset();

        $display("[TB] clean lock, phase 0");
        runSymbols(LOCK_SYMS - 1, 1'b0);
        checkOutput("prelock_locked", 64'(o_locked), 64'd0);
        runSymbols(1, 1'b0);
        checkOutput("lock_locked",  64'(o_locked),  64'd1);
        checkOutput("lock_delay",   64'(o_delay),   TRUE_DELAY);
        checkOutput("lock_min_err", 64'(o_min_err), 64'd0);

        runSymbols(1000, 1'b0);
        checkOutput("clean_bit_cnt", 64'(o_bit_cnt), 64'd1000);
        checkOutput("clean_err_cnt", 64'(o_err_cnt), 64'd0);

        $display("[TB] restart coincident with symbol strobe");
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("restart_locked",  64'(o_locked),  64'd0);
        checkOutput("restart_bit_cnt", 64'(o_bit_cnt), 64'd0);
        checkOutput("restart_err_cnt", 64'(o_err_cnt), 64'd0);
        checkOutput("restart_min_err", 64'(o_min_err), MIN_ERR_RST);
        runSymbols(LOCK_SYMS - 1, 1'b0);
        checkOutput("relock_pre_locked", 64'(o_locked), 64'd0);
        runSymbols(1, 1'b0);
        checkOutput("relock_locked",  64'(o_locked),  64'd1);
        checkOutput("relock_delay",   64'(o_delay),   TRUE_DELAY);
        checkOutput("relock_min_err", 64'(o_min_err), 64'd0);

        $display("[TB] error injection every 100th symbol");
        for (int k = 0; k < 1000; k++) begin
            applyStimulus((k % 100) == 99, 1'b0, 1'b0);
        end
        checkOutput("inject_bit_cnt", 64'(o_bit_cnt), 64'd1000);
        checkOutput("inject_err_cnt", 64'(o_err_cnt), 64'd10);

        $display("[TB] asynchronous reset while locked");
        #1 rst = 1'b0;
        #1;
        checkResetState("async_rst");
        releaseReset();

        $display("[TB] phase select 2 with wrong sign on other phases");
        i_phase = 2'd2;
        runSymbols(LOCK_SYMS, 1'b1);
        checkOutput("phase_locked",  64'(o_locked),  64'd1);
        checkOutput("phase_delay",   64'(o_delay),   TRUE_DELAY);
        checkOutput("phase_min_err", 64'(o_min_err), 64'd0);
        runSymbols(200, 1'b1);
        checkOutput("phase_bit_cnt", 64'(o_bit_cnt), 64'd200);
        checkOutput("phase_err_cnt", 64'(o_err_cnt), 64'd0);

        $display("[TB] counter saturation");
        for (int k = 0; k < 1100; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b1);
        end
        checkOutput("sat_bit_cnt", 64'(o_bit_cnt), CNT_SAT);
        checkOutput("sat_err_cnt", 64'(o_err_cnt), CNT_SAT);
        checkOutput("sat_locked",  64'(o_locked),  64'd1);

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/qpsk_ber_checker.md
Name: qpsk_ber_checker

Overview:
- Receive-side check stage placed directly downstream of the QPSK tx polyphase shaping filter.
- Consumes the filter's 8-bit signed sample stream at the oversampled rate (4 samples/symbol), picks one sampling phase and makes a hard sign decision per symbol.
- Compares each decided bit against the reference bit stream that fed the filter. Searches for the reference-to-decision delay, then locks and accumulates bit and error counts for BER readout.

Parameters:
- OS, 4, samples per symbol; phase counter modulus. Must be a power of 2.
- DEPTH, 64, reference delay-line length; number of candidate delays searched.
- WINDOW, 511, symbols per candidate during the search.
- CNT_W, 64, width of the bit and error counters.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- i_enable  in  1  sample strobe; same strobe that advances the tx filter
- i_sample  in  8  signed filter output sample, valid when i_enable=1
- i_phase  in  log2(OS)  sampling phase select; quasi-static
- i_ref  in  1  reference symbol bit, sampled on the symbol strobe
- i_restart  in  1  single-cycle pulse; aborts and restarts the search
- o_locked  out  1  high once the delay is chosen
- o_delay  out  log2(DEPTH)  selected delay index
- o_bit_cnt  out  CNT_W  symbols compared while locked
- o_err_cnt  out  CNT_W  mismatches while locked
- o_min_err  out  log2(WINDOW+1)  best window error count found in the search

Behaviour:
- One clock; every register clears asynchronously while rst=0.
- Reset values:
  - o_locked=0, o_delay=0, o_bit_cnt=0, o_err_cnt=0, o_min_err=all ones.
  - Phase counter=0, delay line=0, state=SEARCH, candidate d=0, window count=0, window error accumulator=0.
- Phase counter:
  - Increments modulo OS on each i_enable; holds otherwise.
  - Symbol strobe sym = i_enable & (phase_cnt == i_phase), evaluated on the pre-increment count.
- Decision: dec = ~i_sample[7], so sample >= 0 gives 1 and sample < 0 gives 0. This matches the tx mapping of 1 to +coef.
- Delay line:
  - On sym: ref_buf <= {ref_buf[DEPTH-2:0], i_ref}.
  - Comparisons use the pre-shift value, so ref_buf[d] is the reference bit from d+1 strobes earlier.
- SEARCH state, on each sym:
  - mis = dec ^ ref_buf[d]; the accumulator adds mis; the window count increments.
  - On the last symbol of a window (count == WINDOW-1), total = acc + mis.
  - If total < o_min_err: o_min_err <= total and best_d <= d. Ties keep the earlier d.
  - Then clear acc and the window count.
  - If d == DEPTH-1: go to LOCKED with o_delay <= best_d (including an update made in this same cycle) and o_locked <= 1 on the next edge.
  - Otherwise d <= d+1.
- LOCKED state, on each sym:
  - o_bit_cnt increments.
  - o_err_cnt increments when dec ^ ref_buf[o_delay].
  - Both counters saturate at all ones and never wrap.
- Latency: counters update on the edge that samples sym, i.e. 1 cycle after the qualifying sample.
- i_restart, in any state:
  - Next edge: state=SEARCH, d=0, acc/window=0, o_min_err=all ones, o_locked=0, both counters=0.
  - The phase counter and delay line keep running.
  - i_restart coincident with sym: restart wins and that symbol is not accumulated; the delay line still shifts.
- Asynchronous reset mid-search or mid-lock: immediate return to reset values; no partial state survives.
- Without the optional feature, search duration is fixed at DEPTH*WINDOW symbol strobes.

Optional Feature:
- Macro BER_EARLY_LOCK_EN.
- Defined: a window with total == 0 locks immediately with o_delay <= d and o_min_err <= 0, skipping the remaining candidates.
- Undefined: all DEPTH candidates are always searched and the minimum is chosen.

Test Plan:
- Reset/idle:
  - Stimulus: assert rst=0 mid-run with counters nonzero.
  - Required: o_locked=0, o_delay=0, counters=0, o_min_err=511, all without a clock edge.
- Clean lock:
  - Stimulus: i_enable=1 every cycle, i_phase=0, i_sample=+64 when i_ref from 5 symbols earlier is 1, else -64, PRBS9 reference.
  - Required: o_locked rises after 64*511=32704 strobes, o_delay=4, o_min_err=0.
  - Then, after 1000 more strobes: o_bit_cnt=1000, o_err_cnt=0.
- Error injection:
  - Stimulus: after lock, invert the sample sign on every 100th symbol for 1000 symbols.
  - Required: o_err_cnt=10, o_bit_cnt=1000.
- Phase select:
  - Stimulus: i_phase=2; correct sign only at phase 2, opposite sign on phases 0/1/3.
  - Required: lock with o_delay=4, o_err_cnt=0.
- Restart:
  - Stimulus: pulse i_restart in LOCKED, coincident with sym.
  - Required: next cycle o_locked=0 and counters=0; relock to the same o_delay after another 32704 strobes.
- Early lock, with BER_EARLY_LOCK_EN defined:
  - Stimulus: clean-lock stimulus.
  - Required: lock after 5*511=2555 strobes, o_delay=4.
